// File: rtl/stripe_tx_sequencer_if.sv
// Handshake and output bundle between the TLP/DLLP sources, the sequencer and the byte striper.
// Latency: none, wires only.
// Backpressure: i_en stalls the whole bundle; the per-source ready signals carry the accept.
// Optional stats outputs appear only when STRIPE_SEQ_STATS_EN is defined.
interface stripe_tx_sequencer_if;
    logic        i_en;
    logic        i_tlp_valid;
    logic [31:0] i_tlp_data;
    logic        i_tlp_last;
    logic        o_tlp_ready;
    logic        i_dllp_valid;
    logic [31:0] i_dllp_data;
    logic        i_dllp_last;
    logic        o_dllp_ready;
    logic [31:0] o_mu_data;
    logic [3:0]  o_d_k_vals;
    logic        o_underrun;
`ifdef STRIPE_SEQ_STATS_EN
    logic [15:0] o_tlp_cnt;
    logic [15:0] o_dllp_cnt;
    logic [15:0] o_skp_cnt;
`endif

    // Source/striper side
    modport master (
        output i_en, i_tlp_valid, i_tlp_data, i_tlp_last,
        output i_dllp_valid, i_dllp_data, i_dllp_last,
        input  o_tlp_ready, o_dllp_ready, o_mu_data, o_d_k_vals, o_underrun
`ifdef STRIPE_SEQ_STATS_EN
        , input o_tlp_cnt, o_dllp_cnt, o_skp_cnt
`endif
    );

    // Sequencer side
    modport slave (
        input  i_en, i_tlp_valid, i_tlp_data, i_tlp_last,
        input  i_dllp_valid, i_dllp_data, i_dllp_last,
        output o_tlp_ready, o_dllp_ready, o_mu_data, o_d_k_vals, o_underrun
`ifdef STRIPE_SEQ_STATS_EN
        , output o_tlp_cnt, o_dllp_cnt, o_skp_cnt
`endif
    );
endinterface

// File: rtl/stripe_tx_sequencer.sv
// Frames TLP/DLLP packets with K-symbols, round-robin arbitrates, inserts SKP sets and idles.
// Latency: 1 cycle, a beat accepted in cycle N is on o_mu_data in cycle N+1.
// Backpressure: i_en=0 freezes everything and drops both readys; STRIPE_SEQ_STATS_EN adds counters.
module stripe_tx_sequencer #(
    parameter int num_lanes    = 4,
    parameter int SKP_INTERVAL = 1180
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    stripe_tx_sequencer_if.slave  bus
);
    // Refuse to elaborate with an unsupported lane count or SKP spacing
    generate
        if (num_lanes != 4) begin : g_bad_lanes
            $fatal(1, "stripe_tx_sequencer: num_lanes must be 4");
        end
        if (SKP_INTERVAL < 16 || SKP_INTERVAL > 65535) begin : g_bad_skp
            $fatal(1, "stripe_tx_sequencer: SKP_INTERVAL must be 16..65535");
        end
    endgenerate

    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [15:0] SKP_LAST = 16'(SKP_INTERVAL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_EOP, ST_SKP} state_t;
    typedef enum logic {SRC_TLP, SRC_DLLP} src_t;

    state_t      state_q, state_d;
    src_t        grant_q, grant_d;
    src_t        last_grant_q, last_grant_d;
    src_t        pick;
    logic [15:0] skp_cnt_q;
    logic        skp_pending_q;
    logic        skp_wrap;
    logic        skp_take;
    logic        end_emit;
    logic [31:0] mu_data_q, mu_data_d;
    logic [3:0]  d_k_q, d_k_d;
    logic        underrun_q, underrun_d;
    logic        g_valid;
    logic [31:0] g_data;
    logic        g_last;

    // Mux the currently granted source
    assign g_valid = (grant_q == SRC_TLP) ? bus.i_tlp_valid : bus.i_dllp_valid;
    assign g_data  = (grant_q == SRC_TLP) ? bus.i_tlp_data  : bus.i_dllp_data;
    assign g_last  = (grant_q == SRC_TLP) ? bus.i_tlp_last  : bus.i_dllp_last;

    assign skp_wrap = (skp_cnt_q == SKP_LAST);

    assign bus.o_tlp_ready  = !i_rst && bus.i_en && (state_q == ST_PAYLOAD) && (grant_q == SRC_TLP);
    assign bus.o_dllp_ready = !i_rst && bus.i_en && (state_q == ST_PAYLOAD) && (grant_q == SRC_DLLP);
    assign bus.o_mu_data    = mu_data_q;
    assign bus.o_d_k_vals   = d_k_q;
    assign bus.o_underrun   = underrun_q;

    // Next-state and next-word selection; SKP state decides like IDLE since its word is already out
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mu_data_d    = mu_data_q;
        d_k_d        = d_k_q;
        underrun_d   = underrun_q;
        skp_take     = 1'b0;
        end_emit     = 1'b0;
        pick         = SRC_TLP;
        case (state_q)
            ST_IDLE, ST_SKP: begin
                if (skp_pending_q) begin
                    mu_data_d = {SYM_SKP, SYM_SKP, SYM_SKP, SYM_COM};
                    d_k_d     = 4'hF;
                    skp_take  = 1'b1;
                    state_d   = ST_SKP;
                end else if (bus.i_tlp_valid || bus.i_dllp_valid) begin
                    if (bus.i_tlp_valid && bus.i_dllp_valid)
                        pick = (last_grant_q == SRC_TLP) ? SRC_DLLP : SRC_TLP;
                    else
                        pick = bus.i_tlp_valid ? SRC_TLP : SRC_DLLP;
                    grant_d      = pick;
                    last_grant_d = pick;
                    mu_data_d    = {SYM_PAD, SYM_PAD, SYM_PAD,
                                    (pick == SRC_TLP) ? SYM_STP : SYM_SDP};
                    d_k_d        = 4'hF;
                    state_d      = ST_PAYLOAD;
                end else begin
                    mu_data_d = 32'h0;
                    d_k_d     = 4'h0;
                    state_d   = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (g_valid) begin
                    mu_data_d = g_data;
                    d_k_d     = 4'h0;
                    if (g_last)
                        state_d = ST_EOP;
                end else begin
                    // Source starved mid-packet: pad the lane and flag it
                    mu_data_d  = {SYM_PAD, SYM_PAD, SYM_PAD, SYM_PAD};
                    d_k_d      = 4'hF;
                    underrun_d = 1'b1;
                end
            end
            ST_EOP: begin
                mu_data_d = {SYM_PAD, SYM_PAD, SYM_PAD, SYM_END};
                d_k_d     = 4'hF;
                end_emit  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered state, word and SKP timer; a fresh wrap wins over consuming the old request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= SRC_TLP;
            last_grant_q  <= SRC_TLP;
            skp_cnt_q     <= 16'h0;
            skp_pending_q <= 1'b0;
            mu_data_q     <= 32'h0;
            d_k_q         <= 4'h0;
            underrun_q    <= 1'b0;
        end else if (bus.i_en) begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mu_data_q    <= mu_data_d;
            d_k_q        <= d_k_d;
            underrun_q   <= underrun_d;
            skp_cnt_q    <= skp_wrap ? 16'h0 : skp_cnt_q + 16'd1;
            if (skp_wrap)
                skp_pending_q <= 1'b1;
            else if (skp_take)
                skp_pending_q <= 1'b0;
        end
    end

`ifdef STRIPE_SEQ_STATS_EN
    logic [15:0] tlp_cnt_q, dllp_cnt_q, skp_sent_q;

    assign bus.o_tlp_cnt  = tlp_cnt_q;
    assign bus.o_dllp_cnt = dllp_cnt_q;
    assign bus.o_skp_cnt  = skp_sent_q;

    // Count completed packets per source and SKP sets, wrapping at 16 bits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tlp_cnt_q  <= 16'h0;
            dllp_cnt_q <= 16'h0;
            skp_sent_q <= 16'h0;
        end else if (bus.i_en) begin
            if (end_emit && grant_q == SRC_TLP)
                tlp_cnt_q <= tlp_cnt_q + 16'd1;
            if (end_emit && grant_q == SRC_DLLP)
                dllp_cnt_q <= dllp_cnt_q + 16'd1;
            if (skp_take)
                skp_sent_q <= skp_sent_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stripe_tx_sequencer.sv
// Directed bench for stripe_tx_sequencer with a packet-level reference model checked every cycle.
// Latency: model predicts the registered word one cycle after the inputs it consumes.
// Backpressure: sources hold a beat until the DUT ready accepts it; i_en stalls are directed.
module tb_stripe_tx_sequencer;
    localparam int SKP_I = 16;
    localparam logic [31:0] W_STP = 32'hF7F7F7FB;
    localparam logic [31:0] W_SDP = 32'hF7F7F75C;
    localparam logic [31:0] W_END = 32'hF7F7F7FD;
    localparam logic [31:0] W_PAD = 32'hF7F7F7F7;
    localparam logic [31:0] W_SKP = 32'h1C1C1CBC;

    typedef struct {
        logic [31:0] d;
        logic        last;
        logic        bubble;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        tv = 1'b0, tl = 1'b0, dv = 1'b0, dl = 1'b0;
    logic [31:0] td = 32'h0, dd = 32'h0;
    logic        chk_on = 1'b0;
    int          checks = 0;
    int          errors = 0;

    beat_t       tq[$];
    beat_t       dq[$];

    always #5 clk = ~clk;

    stripe_tx_sequencer_if bus();

    assign bus.i_en         = en;
    assign bus.i_tlp_valid  = tv;
    assign bus.i_tlp_data   = td;
    assign bus.i_tlp_last   = tl;
    assign bus.i_dllp_valid = dv;
    assign bus.i_dllp_data  = dd;
    assign bus.i_dllp_last  = dl;

    stripe_tx_sequencer #(.num_lanes(4), .SKP_INTERVAL(SKP_I)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // TLP source: holds head beat until accepted; a bubble entry drops valid for one cycle
    logic t_acc = 1'b0, t_bub = 1'b0;
    always begin
        @(negedge clk);
        t_acc = tv && bus.o_tlp_ready;
        @(posedge clk);
        #1;
        if (rst) tq.delete();
        else if ((t_acc || t_bub) && tq.size() > 0) void'(tq.pop_front());
        t_bub = 1'b0; tv = 1'b0; td = 32'h0; tl = 1'b0;
        if (tq.size() > 0) begin
            if (tq[0].bubble) t_bub = 1'b1;
            else begin tv = 1'b1; td = tq[0].d; tl = tq[0].last; end
        end
    end

    // DLLP source, same behaviour
    logic d_acc = 1'b0, d_bub = 1'b0;
    always begin
        @(negedge clk);
        d_acc = dv && bus.o_dllp_ready;
        @(posedge clk);
        #1;
        if (rst) dq.delete();
        else if ((d_acc || d_bub) && dq.size() > 0) void'(dq.pop_front());
        d_bub = 1'b0; dv = 1'b0; dd = 32'h0; dl = 1'b0;
        if (dq.size() > 0) begin
            if (dq[0].bubble) d_bub = 1'b1;
            else begin dv = 1'b1; dd = dq[0].d; dl = dq[0].last; end
        end
    end

    // Reference model: packet view plus SKP requests tracked as "last wrap index vs last SKP index"
    logic [31:0] m_data = 32'h0;
    logic [3:0]  m_dk = 4'h0;
    logic        m_under = 1'b0, m_in_pkt = 1'b0, m_end_due = 1'b0;
    logic        m_src = 1'b0, m_last_grant = 1'b0;
    int          m_k = 0, m_last_wrap = -2, m_last_skp = -1;
    logic [15:0] m_tcnt = 16'h0, m_dcnt = 16'h0, m_scnt = 16'h0;
    logic [31:0] lg_d[$];
    logic [3:0]  lg_k[$];

    always @(posedge clk) begin
        if (rst) begin
            m_data = 32'h0; m_dk = 4'h0; m_under = 1'b0; m_in_pkt = 1'b0; m_end_due = 1'b0;
            m_src = 1'b0; m_last_grant = 1'b0; m_k = 0; m_last_wrap = -2; m_last_skp = -1;
            m_tcnt = 16'h0; m_dcnt = 16'h0; m_scnt = 16'h0;
            lg_d.delete(); lg_k.delete();
        end else if (en) begin
            if (m_end_due) begin
                m_data = W_END; m_dk = 4'hF; m_end_due = 1'b0;
                if (m_src) m_dcnt = m_dcnt + 16'd1; else m_tcnt = m_tcnt + 16'd1;
            end else if (m_in_pkt) begin
                if (m_src ? dv : tv) begin
                    m_data = m_src ? dd : td; m_dk = 4'h0;
                    if (m_src ? dl : tl) begin m_in_pkt = 1'b0; m_end_due = 1'b1; end
                end else begin
                    m_data = W_PAD; m_dk = 4'hF; m_under = 1'b1;
                end
            end else if (m_last_wrap >= m_last_skp) begin
                m_data = W_SKP; m_dk = 4'hF; m_last_skp = m_k; m_scnt = m_scnt + 16'd1;
            end else if (tv || dv) begin
                m_src = (tv && dv) ? !m_last_grant : dv;
                m_last_grant = m_src; m_in_pkt = 1'b1;
                m_data = m_src ? W_SDP : W_STP; m_dk = 4'hF;
            end else begin
                m_data = 32'h0; m_dk = 4'h0;
            end
            if (m_k % SKP_I == SKP_I - 1) m_last_wrap = m_k;
            m_k++;
            lg_d.push_back(m_data);
            lg_k.push_back(m_dk);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        chk_on = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("mu_data", bus.o_mu_data, m_data);
            check("d_k", {28'h0, bus.o_d_k_vals}, {28'h0, m_dk});
            check("underrun", {31'h0, bus.o_underrun}, {31'h0, m_under});
            check("tlp_ready", {31'h0, bus.o_tlp_ready},
                  {31'h0, !rst && en && m_in_pkt && !m_src});
            check("dllp_ready", {31'h0, bus.o_dllp_ready},
                  {31'h0, !rst && en && m_in_pkt && m_src});
`ifdef STRIPE_SEQ_STATS_EN
            check("tlp_cnt", {16'h0, bus.o_tlp_cnt}, {16'h0, m_tcnt});
            check("dllp_cnt", {16'h0, bus.o_dllp_cnt}, {16'h0, m_dcnt});
            check("skp_cnt", {16'h0, bus.o_skp_cnt}, {16'h0, m_scnt});
`endif
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((tq.size() + dq.size()) != 0 && n < budget) begin
            step(1);
            n++;
        end
        check(nm, 32'(tq.size() + dq.size()), 32'h0);
    endtask

    function automatic beat_t bt(input logic [31:0] d, input logic last, input logic bubble);
        beat_t b;
        b.d = d; b.last = last; b.bubble = bubble;
        return b;
    endfunction

    function automatic int find_word(input logic [31:0] w);
        for (int i = 0; i < lg_d.size(); i++)
            if (lg_d[i] === w) return i;
        return -1;
    endfunction

    logic [31:0] ex_d[$];
    logic [3:0]  ex_k[$];

    // Pin the model's word log against a hand-written sequence starting at index p
    task automatic pin(input string nm, input int p);
        for (int i = 0; i < ex_d.size(); i++) begin
            logic [31:0] ad;
            logic [3:0]  ak;
            ad = 'x; ak = 'x;
            if (p >= 0 && p + i < lg_d.size()) begin ad = lg_d[p + i]; ak = lg_k[p + i]; end
            check($sformatf("%s_w%0d", nm, i), ad, ex_d[i]);
            check($sformatf("%s_k%0d", nm, i), {28'h0, ak}, {28'h0, ex_k[i]});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int n;

        // Idle after reset
        do_reset();
        step(10);
        check("t1_log_len", 32'(lg_d.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check("t1_idle_word", lg_d[i], 32'h0);
            check("t1_idle_dk", {28'h0, lg_k[i]}, 32'h0);
        end

        // Three-beat TLP
        do_reset();
        tq.push_back(bt(32'h11223344, 1'b0, 1'b0));
        tq.push_back(bt(32'h55667788, 1'b0, 1'b0));
        tq.push_back(bt(32'h99AABBCC, 1'b1, 1'b0));
        drain("t2_drain", 60);
        step(4);
        ex_d = '{W_STP, 32'h11223344, 32'h55667788, 32'h99AABBCC, W_END};
        ex_k = '{4'hF, 4'h0, 4'h0, 4'h0, 4'hF};
        pin("t2", find_word(W_STP));

        // Simultaneous requests: DLLP wins the first tie, TLP follows with no gap
        do_reset();
        dq.push_back(bt(32'hD0D0D0D0, 1'b1, 1'b0));
        tq.push_back(bt(32'hA1A1A1A1, 1'b0, 1'b0));
        tq.push_back(bt(32'hA2A2A2A2, 1'b1, 1'b0));
        drain("t3_drain", 60);
        step(4);
        ex_d = '{W_SDP, 32'hD0D0D0D0, W_END, W_STP, 32'hA1A1A1A1, 32'hA2A2A2A2, W_END};
        ex_k = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF};
        pin("t3", find_word(W_SDP));

        // Long TLP spans two timer wraps: exactly one SKP after END, then the queued TLP
        do_reset();
        step(10);
        for (int i = 0; i < 22; i++)
            tq.push_back(bt(32'h00001000 + 32'(i), (i == 21), 1'b0));
        tq.push_back(bt(32'hCAFEF00D, 1'b1, 1'b0));
        drain("t4_drain", 120);
        step(4);
        p = find_word(W_STP);
        check("t4_sop_pos", 32'(p), 32'd11);
        ex_d = '{W_END, W_SKP, W_STP, 32'hCAFEF00D, W_END};
        ex_k = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF};
        pin("t4", p + 23);
        n = 0;
        for (int i = 0; i <= p + 27 && i < lg_d.size(); i++)
            if (lg_d[i] === W_SKP) n++;
        check("t4_one_skp", 32'(n), 32'd1);

        // Three-cycle stall mid-payload
        do_reset();
        for (int i = 0; i < 4; i++)
            tq.push_back(bt(32'hB0B00000 + 32'(i), (i == 3), 1'b0));
        step(3);
        en = 1'b0;
        step(1);
        check("t5_hold_word", bus.o_mu_data, 32'hB0B00000);
        check("t5_hold_rdy", {31'h0, bus.o_tlp_ready}, 32'h0);
        step(2);
        en = 1'b1;
        drain("t5_drain", 60);
        step(4);
        ex_d = '{W_STP, 32'hB0B00000, 32'hB0B00001, 32'hB0B00002, 32'hB0B00003, W_END};
        ex_k = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        pin("t5", find_word(W_STP));

        // Underrun padding, sticky flag, then reset mid-packet
        do_reset();
        tq.push_back(bt(32'hC0C0C0C0, 1'b0, 1'b0));
        tq.push_back(bt(32'h0, 1'b0, 1'b1));
        tq.push_back(bt(32'hC1C1C1C1, 1'b1, 1'b0));
        drain("t6_drain", 60);
        step(4);
        ex_d = '{W_STP, 32'hC0C0C0C0, W_PAD, 32'hC1C1C1C1, W_END};
        ex_k = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
        pin("t6", find_word(W_STP));
        check("t6_under_set", {31'h0, bus.o_underrun}, 32'h1);
        for (int i = 0; i < 8; i++)
            tq.push_back(bt(32'hE0000000 + 32'(i), (i == 7), 1'b0));
        step(4);
        do_reset();
        step(3);
        check("t6_under_clr", {31'h0, bus.o_underrun}, 32'h0);
        ex_d = '{32'h0, 32'h0, 32'h0};
        ex_k = '{4'h0, 4'h0, 4'h0};
        pin("t6_rst", 0);
        check("t6_no_end", 32'(find_word(W_END)), 32'hFFFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
